// File: rtl/apu_pkg.sv
// Shared definitions for the APU pulse-channel register loader.
// Holds the address-byte marker, the frame and bit FSM state types and
// the register index constants used by the loader and its UART core.
package apu_pkg;

   // Upper six bits of an address byte: 8'b1000_00aa.
   localparam logic [5:0] ADDR_MARKER = 6'b100000;

   // Register indices into the pulse-channel register set.
   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_SWEEP    = 2'd1;
   localparam logic [1:0] REG_TIMER_LO = 2'd2;
   localparam logic [1:0] REG_TIMER_HI = 2'd3;

   typedef enum logic {
      FrameWaitAddr,
      FrameWaitData
   } frame_state_e;

   typedef enum logic [1:0] {
      BitIdle,
      BitStart,
      BitData,
      BitStop
   } bit_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: 2-FF input synchronizer plus bit-level FSM.
// Ports:
//   apu_clk    in   clock, all state on posedge
//   reset      in   asynchronous active-high reset
//   rx_in      in   raw serial input, idle high
//   byte_data  out  last received byte (valid with byte_valid)
//   byte_valid out  one-cycle pulse in the stop-bit sample cycle, stop bit high
//   frame_err  out  one-cycle pulse in the stop-bit sample cycle, stop bit low
//   line_idle  out  bit FSM idle and synchronized line high
module uart_rx_core
   import apu_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       apu_clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       line_idle
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HalfLast = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BitLast  = TW'(CLKS_PER_BIT - 1);

   logic [1:0]    sync_q;
   logic          rx_prev_q;
   bit_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          rx_s;

   assign rx_s = sync_q[1];

   always_ff @(posedge apu_clk or posedge reset) begin
      if (reset) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
         state_q   <= BitIdle;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         sync_q    <= {sync_q[0], rx_in};
         rx_prev_q <= rx_s;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      unique case (state_q)
         BitIdle: begin
            // Only a falling edge seen from idle starts a byte.
            if (rx_prev_q && !rx_s) begin
               state_d = BitStart;
               timer_d = '0;
            end
         end
         BitStart: begin
            if (timer_q == HalfLast) begin
               timer_d   = '0;
               bit_idx_d = '0;
               // Line back high at mid start bit: glitch, not a start.
               state_d   = rx_s ? BitIdle : BitData;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         BitData: begin
            if (timer_q == BitLast) begin
               timer_d   = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) begin
                  state_d = BitStop;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         BitStop: begin
            if (timer_q == BitLast) begin
               timer_d    = '0;
               byte_valid = rx_s;
               frame_err  = !rx_s;
               state_d    = BitIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = BitIdle;
      endcase
   end

   assign byte_data = shift_q;
   assign line_idle = (state_q == BitIdle) && rx_s;

endmodule

// File: rtl/apu_reg_loader.sv
// Serial loader for the 4-byte pulse-channel register set.
// Frames are an address byte (8'b1000_00aa) followed by a data byte.
// Ports:
//   apu_clk    in   clock
//   reset      in   asynchronous active-high reset
//   rx_in      in   UART serial input, idle high
//   reg_0..3   out  pulse-channel registers
//   wr_strobe  out  one-cycle pulse on any register write
//   wr_addr    out  index of the last register written
//   restart    out  one-cycle pulse with wr_strobe when reg_3 is written
//   frame_err  out  one-cycle pulse on a bad stop bit
module apu_reg_loader
   import apu_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned RESYNC_BITS  = 20
) (
   input  logic       apu_clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] reg_0,
   output logic [7:0] reg_1,
   output logic [7:0] reg_2,
   output logic [7:0] reg_3,
   output logic       wr_strobe,
   output logic [1:0] wr_addr,
   output logic       restart,
   output logic       frame_err
);

   localparam int unsigned ResyncCycles = RESYNC_BITS * CLKS_PER_BIT;
   localparam int unsigned RW = $clog2(ResyncCycles + 1);
   localparam logic [RW-1:0] ResyncLimit = RW'(ResyncCycles);

   logic [7:0]   byte_data;
   logic         byte_valid;
   logic         rx_frame_err;
   logic         line_idle;

   frame_state_e frame_q, frame_d;
   logic [1:0]   addr_q, addr_d;
   logic [RW-1:0] resync_q, resync_d;
   logic         wr_en;
   logic [7:0]   regs_q [4];
   logic         wr_strobe_q;
   logic [1:0]   wr_addr_q;
   logic         restart_q;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .apu_clk   (apu_clk),
      .reset     (reset),
      .rx_in     (rx_in),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .frame_err (rx_frame_err),
      .line_idle (line_idle)
   );

   always_comb begin
      frame_d = frame_q;
      addr_d  = addr_q;
      wr_en   = 1'b0;
      if (rx_frame_err) begin
         frame_d = FrameWaitAddr;
      end else if (byte_valid) begin
         unique case (frame_q)
            FrameWaitAddr: begin
               if (byte_data[7:2] == ADDR_MARKER) begin
                  addr_d  = byte_data[1:0];
                  frame_d = FrameWaitData;
               end
            end
            FrameWaitData: begin
               wr_en   = 1'b1;
               frame_d = FrameWaitAddr;
            end
            default: frame_d = FrameWaitAddr;
         endcase
      end else if (frame_q == FrameWaitData && resync_q == ResyncLimit) begin
         // Host went quiet mid-frame: drop the pending address.
         frame_d = FrameWaitAddr;
      end
   end

   // Counts idle-line cycles while waiting for data; any activity clears it.
   always_comb begin
      resync_d = '0;
      if (frame_q == FrameWaitData && line_idle) begin
         resync_d = (resync_q == ResyncLimit) ? resync_q : resync_q + 1'b1;
      end
   end

   always_ff @(posedge apu_clk or posedge reset) begin
      if (reset) begin
         frame_q     <= FrameWaitAddr;
         addr_q      <= '0;
         resync_q    <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         restart_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         frame_q     <= frame_d;
         addr_q      <= addr_d;
         resync_q    <= resync_d;
         wr_strobe_q <= wr_en;
         restart_q   <= wr_en && (addr_q == REG_TIMER_HI);
         if (wr_en) begin
            regs_q[addr_q] <= byte_data;
            wr_addr_q      <= addr_q;
         end
      end
   end

   assign reg_0     = regs_q[REG_CTRL];
   assign reg_1     = regs_q[REG_SWEEP];
   assign reg_2     = regs_q[REG_TIMER_LO];
   assign reg_3     = regs_q[REG_TIMER_HI];
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign restart   = restart_q;
   assign frame_err = rx_frame_err;

endmodule
